// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if
//   Bundles the word-source handshake and the serial-line outputs of the
//   piso_shift_tx transmitter.
//
//   Signals:
//     load_valid  - source offers parallel_in
//     parallel_in - N-bit word to transmit
//     load_ready  - transmitter can accept a word this cycle
//     serial_out  - current bit on the serial line (MSB first)
//     frame_en    - high for every bit cycle of a word (receiver enable)
//     word_done   - one-cycle pulse after the last bit of a word
//
//   Modports:
//     master - the word source / line observer side
//     slave  - the transmitter itself
interface piso_shift_tx_if #(
  parameter int N = 4
);
  logic         load_valid;
  logic [N-1:0] parallel_in;
  logic         load_ready;
  logic         serial_out;
  logic         frame_en;
  logic         word_done;

  modport master (
    output load_valid,
    output parallel_in,
    input  load_ready,
    input  serial_out,
    input  frame_en,
    input  word_done
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    output load_ready,
    output serial_out,
    output frame_en,
    output word_done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// piso_shift_tx
//   Parallel-in / serial-out transmitter. It accepts an N-bit word through a
//   valid/ready handshake and shifts it out MSB first, one bit per clock.
//   frame_en frames the word for a SIPO receiver. word_done pulses in the
//   cycle where that receiver's parallel output holds the complete word.
//   A new word can be accepted on the last bit cycle of the current one, so
//   back-to-back words leave no gap on the line.
//
//   Ports:
//     clk - rising-edge clock
//     rst - asynchronous active-high reset
//     bus - piso_shift_tx_if slave modport (handshake + serial outputs)
module piso_shift_tx #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  piso_shift_tx_if.slave   bus
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     sreg;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(N - 1));

  // Ready is decoded from the registered state. It is also gated by rst,
  // because the state already reads IDLE while reset is held, yet no word
  // may be taken until reset is released.
  assign bus.load_ready = !rst && ((state == IDLE) || last_bit);
  assign accept         = bus.load_valid && bus.load_ready;

  // Single FSM process. serial_out always mirrors the bit that sreg[N-1]
  // will hold after this edge, so the line is registered. It never takes a
  // path straight from parallel_in. Leaving SHIFT clears sreg, which holds
  // the idle line at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      sreg           <= '0;
      bus.serial_out <= 1'b0;
      bus.frame_en   <= 1'b0;
      bus.word_done  <= 1'b0;
    end else begin
      bus.word_done <= last_bit;
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= SHIFT;
            sreg           <= bus.parallel_in;
            cnt            <= '0;
            bus.serial_out <= bus.parallel_in[N-1];
            bus.frame_en   <= 1'b1;
          end else begin
            bus.serial_out <= 1'b0;
            bus.frame_en   <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (accept) begin
              sreg           <= bus.parallel_in;
              cnt            <= '0;
              bus.serial_out <= bus.parallel_in[N-1];
              bus.frame_en   <= 1'b1;
            end else begin
              state          <= IDLE;
              sreg           <= '0;
              cnt            <= '0;
              bus.serial_out <= 1'b0;
              bus.frame_en   <= 1'b0;
            end
          end else begin
            sreg           <= sreg << 1;
            cnt            <= cnt + 1'b1;
            bus.serial_out <= sreg[N-2];
            bus.frame_en   <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          sreg           <= '0;
          cnt            <= '0;
          bus.serial_out <= 1'b0;
          bus.frame_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx
//   Directed bench for piso_shift_tx. It holds an N=4 and an N=8 instance.
//   Each instance feeds a behavioural SIPO receiver that is looped back from
//   the serial line. Inputs are driven, and outputs are sampled, 1 time unit
//   after each rising edge.
module tb_piso_shift_tx;

  logic clk;
  logic rst;

  int errors;
  int checks;

  piso_shift_tx_if #(.N(4)) bus4 ();
  piso_shift_tx_if #(.N(8)) bus8 ();

  piso_shift_tx #(.N(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  piso_shift_tx #(.N(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Looped-back SIPO receivers, as the real link's receiving end would be wired
  logic [3:0] sipo4;
  logic [7:0] sipo8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sipo4 <= '0;
    else if (bus4.frame_en) sipo4 <= {sipo4[2:0], bus4.serial_out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sipo8 <= '0;
    else if (bus8.frame_en) sipo8 <= {sipo8[6:0], bus8.serial_out};
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values while reset is held with valid asserted, then ready after release
  task automatic test_reset();
    rst = 1'b1;
    bus4.load_valid = 1'b1;
    bus4.parallel_in = 4'b1011;
    bus8.load_valid = 1'b1;
    bus8.parallel_in = 8'hFF;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus4.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready4: got %b expected 0", bus4.load_ready); end
    checks++;
    if (bus4.frame_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_en: got %b expected 0", bus4.frame_en); end
    checks++;
    if (bus4.serial_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_serial_out: got %b expected 0", bus4.serial_out); end
    checks++;
    if (bus4.word_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_word_done: got %b expected 0", bus4.word_done); end
    checks++;
    if (bus8.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready8: got %b expected 0", bus8.load_ready); end
    bus4.load_valid = 1'b0;
    bus8.load_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready4: got %b expected 1", bus4.load_ready); end
    step();
    checks++;
    if (bus4.frame_en !== 1'b0) begin errors++; $display("[TB] FAIL release_frame_en: got %b expected 0", bus4.frame_en); end
  endtask

  // One word of 1011 followed by a return to idle
  task automatic test_single_word();
    logic [3:0] w;
    w = 4'b1011;
    bus4.parallel_in = w;
    bus4.load_valid = 1'b1;
    checks++;
    if (bus4.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_idle: got %b expected 1", bus4.load_ready); end
    step();
    bus4.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus4.frame_en !== 1'b1) begin errors++; $display("[TB] FAIL single_frame_en[%0d]: got %b expected 1", k, bus4.frame_en); end
      checks++;
      if (bus4.serial_out !== w[3-k]) begin errors++; $display("[TB] FAIL single_bit[%0d]: got %b expected %b", k, bus4.serial_out, w[3-k]); end
      checks++;
      if (bus4.word_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_early[%0d]: got %b expected 0", k, bus4.word_done); end
      step();
    end
    checks++;
    if (bus4.word_done !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %b expected 1", bus4.word_done); end
    checks++;
    if (sipo4 !== w) begin errors++; $display("[TB] FAIL single_sipo: got %b expected %b", sipo4, w); end
    checks++;
    if (bus4.frame_en !== 1'b0) begin errors++; $display("[TB] FAIL single_frame_end: got %b expected 0", bus4.frame_en); end
    checks++;
    if (bus4.serial_out !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_line: got %b expected 0", bus4.serial_out); end
    checks++;
    if (bus4.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_after: got %b expected 1", bus4.load_ready); end
    step();
    checks++;
    if (bus4.word_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %b expected 0", bus4.word_done); end
  endtask

  // Two words with valid held: eight unbroken bit cycles
  task automatic test_back_to_back();
    logic [3:0] w1;
    logic [3:0] w2;
    logic [7:0] stream;
    w1 = 4'b1011;
    w2 = 4'b0110;
    stream = {w1, w2};
    bus4.parallel_in = w1;
    bus4.load_valid = 1'b1;
    step();
    bus4.parallel_in = w2;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) bus4.load_valid = 1'b0;
      checks++;
      if (bus4.frame_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_frame_en[%0d]: got %b expected 1", k, bus4.frame_en); end
      checks++;
      if (bus4.serial_out !== stream[7-k]) begin errors++; $display("[TB] FAIL b2b_bit[%0d]: got %b expected %b", k, bus4.serial_out, stream[7-k]); end
      checks++;
      if (bus4.load_ready !== ((k % 4) == 3)) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, bus4.load_ready, ((k % 4) == 3)); end
      checks++;
      if (bus4.word_done !== (k == 4)) begin errors++; $display("[TB] FAIL b2b_done[%0d]: got %b expected %b", k, bus4.word_done, (k == 4)); end
      if (k == 4) begin
        checks++;
        if (sipo4 !== w1) begin errors++; $display("[TB] FAIL b2b_sipo_first: got %b expected %b", sipo4, w1); end
      end
      step();
    end
    checks++;
    if (bus4.word_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_second: got %b expected 1", bus4.word_done); end
    checks++;
    if (sipo4 !== w2) begin errors++; $display("[TB] FAIL b2b_sipo_second: got %b expected %b", sipo4, w2); end
    checks++;
    if (bus4.frame_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_frame_end: got %b expected 0", bus4.frame_en); end
    step();
  endtask

  // The source swaps in 1111 mid-word; it must wait for the last bit cycle
  task automatic test_backpressure();
    logic [3:0] w;
    w = 4'b1011;
    bus4.parallel_in = w;
    bus4.load_valid = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bus4.parallel_in = 4'b1111;
      checks++;
      if (bus4.serial_out !== w[3-k]) begin errors++; $display("[TB] FAIL bp_bit[%0d]: got %b expected %b", k, bus4.serial_out, w[3-k]); end
      checks++;
      if (bus4.load_ready !== (k == 3)) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", k, bus4.load_ready, (k == 3)); end
      step();
    end
    bus4.load_valid = 1'b0;
    checks++;
    if (bus4.word_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_first: got %b expected 1", bus4.word_done); end
    checks++;
    if (sipo4 !== w) begin errors++; $display("[TB] FAIL bp_sipo_first: got %b expected %b", sipo4, w); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus4.serial_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_bit[%0d]: got %b expected 1", k, bus4.serial_out); end
      checks++;
      if (bus4.frame_en !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_frame[%0d]: got %b expected 1", k, bus4.frame_en); end
      step();
    end
    checks++;
    if (bus4.word_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_second: got %b expected 1", bus4.word_done); end
    checks++;
    if (sipo4 !== 4'b1111) begin errors++; $display("[TB] FAIL bp_sipo_second: got %b expected 1111", sipo4); end
    step();
  endtask

  // Reset in the middle of 1100 and then a clean 0101
  task automatic test_reset_mid_frame();
    logic [3:0] w;
    logic [3:0] w2;
    w = 4'b1100;
    w2 = 4'b0101;
    bus4.parallel_in = w;
    bus4.load_valid = 1'b1;
    step();
    bus4.load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus4.serial_out !== w[3-k]) begin errors++; $display("[TB] FAIL rmf_bit[%0d]: got %b expected %b", k, bus4.serial_out, w[3-k]); end
      if (k < 2) step();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus4.frame_en !== 1'b0) begin errors++; $display("[TB] FAIL rmf_frame_en: got %b expected 0", bus4.frame_en); end
    checks++;
    if (bus4.serial_out !== 1'b0) begin errors++; $display("[TB] FAIL rmf_serial_out: got %b expected 0", bus4.serial_out); end
    checks++;
    if (bus4.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmf_ready: got %b expected 0", bus4.load_ready); end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmf_ready_after: got %b expected 1", bus4.load_ready); end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (bus4.word_done !== 1'b0) begin errors++; $display("[TB] FAIL rmf_no_done[%0d]: got %b expected 0", j, bus4.word_done); end
    end
    bus4.parallel_in = w2;
    bus4.load_valid = 1'b1;
    step();
    bus4.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus4.serial_out !== w2[3-k]) begin errors++; $display("[TB] FAIL rmf_next_bit[%0d]: got %b expected %b", k, bus4.serial_out, w2[3-k]); end
      step();
    end
    checks++;
    if (bus4.word_done !== 1'b1) begin errors++; $display("[TB] FAIL rmf_next_done: got %b expected 1", bus4.word_done); end
    checks++;
    if (sipo4 !== w2) begin errors++; $display("[TB] FAIL rmf_next_sipo: got %b expected %b", sipo4, w2); end
    step();
  endtask

  // Eight-bit instance carrying A5
  task automatic test_width8();
    logic [7:0] w;
    w = 8'hA5;
    bus8.parallel_in = w;
    bus8.load_valid = 1'b1;
    step();
    bus8.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus8.frame_en !== 1'b1) begin errors++; $display("[TB] FAIL w8_frame_en[%0d]: got %b expected 1", k, bus8.frame_en); end
      checks++;
      if (bus8.serial_out !== w[7-k]) begin errors++; $display("[TB] FAIL w8_bit[%0d]: got %b expected %b", k, bus8.serial_out, w[7-k]); end
      checks++;
      if (bus8.word_done !== 1'b0) begin errors++; $display("[TB] FAIL w8_done_early[%0d]: got %b expected 0", k, bus8.word_done); end
      step();
    end
    checks++;
    if (bus8.word_done !== 1'b1) begin errors++; $display("[TB] FAIL w8_done: got %b expected 1", bus8.word_done); end
    checks++;
    if (sipo8 !== w) begin errors++; $display("[TB] FAIL w8_sipo: got %h expected %h", sipo8, w); end
    checks++;
    if (bus8.frame_en !== 1'b0) begin errors++; $display("[TB] FAIL w8_frame_end: got %b expected 0", bus8.frame_en); end
    step();
  endtask

  // Test sequence
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus4.load_valid = 1'b0;
    bus4.parallel_in = '0;
    bus8.load_valid = 1'b0;
    bus8.parallel_in = '0;
    #1;
    $display("[TB] starting piso_shift_tx directed tests");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parameterised parallel-in/serial-out transmitter. It is the sending end of the serial link whose receiving end is our SIPO shift register: it accepts an N-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock. It drives an enable that frames the word for the receiver and a `word_done` strobe marking the cycle in which the receiver's parallel output holds the complete word. It sits between a word source (FIFO, register bank) and the serial line.

## Interface

**Parameters**
- `N`, default 4: word width in bits; legal range N >= 2.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock, rising-edge active.
- `rst`, in, 1: asynchronous, active-high reset.
- `load_valid`, in, 1: source offers `parallel_in`.
- `parallel_in`, in, N: word to transmit; sampled only on an accepted handshake.
- `load_ready`, out, 1: block can accept a word this cycle.
- `serial_out`, out, 1: current bit on the line; receiver samples it on the next rising edge.
- `frame_en`, out, 1: high for every bit cycle of a word; connects to the receiver's `en`.
- `word_done`, out, 1: one-cycle pulse in the cycle after the last bit of a word.

## Operation

**Reset and reset values**
- One clock domain. Reset is asynchronous and active-high.
- On `rst` assertion, all state clears immediately: state = IDLE, `cnt` = 0, shift register = 0.
- Outputs during and after reset: `serial_out`=0, `frame_en`=0, `word_done`=0.
- `load_ready` = 0 while `rst`=1, and 1 in IDLE after release.

**States**
- IDLE:
  - `frame_en`=0, `serial_out`=0, `load_ready`=1.
  - On accept (`load_valid && load_ready`), go to SHIFT, load `sreg <= parallel_in`, `cnt <= 0`.
- SHIFT:
  - `frame_en`=1.
  - `serial_out` = `sreg[N-1]` (registered output, not combinational from `parallel_in`).
  - Each clock: `sreg <= sreg << 1`, `cnt <= cnt+1`.
- Last bit cycle (SHIFT with `cnt == N-1`):
  - `load_ready`=1.
  - If accept occurs, reload `sreg` and `cnt <= 0`, and stay in SHIFT. This is back-to-back operation with no gap; `frame_en` stays high.
  - Otherwise go to IDLE.
- `load_ready`=0 in SHIFT when `cnt < N-1`. `load_valid` in those cycles is ignored and does not consume data; the source holds its word until ready.

**Done strobe**
- `word_done` is registered high for exactly one cycle following every SHIFT cycle with `cnt == N-1`, whether the next cycle is IDLE or a new word's first bit.

**Counter width**
- `cnt` is `$clog2(N)` bits and never exceeds N-1.

## Timing

- **Load latency:** handshake accepted at edge E0 → first bit (MSB) on `serial_out` and `frame_en`=1 in the cycle after E0.
- **Frame length:** bit k (k = 0..N-1, MSB first) is present in cycle k after E0, so `frame_en` is high for exactly N cycles per word.
- **Done timing:** `word_done` is high in cycle N after E0. A SIPO receiver clocked by the same `clk`, with `en=frame_en` and `serial_in=serial_out`, shows `parallel_out == word` in that same cycle.
- **Throughput:** back-to-back words achieve one word every N cycles with 100% line utilisation.
- **Simultaneous events:**
  - Accept on the last bit cycle and `word_done` for the previous word occur together.
  - The new word's MSB appears in the same cycle `word_done` is high.
- **Reset mid-frame:**
  - Outputs drop asynchronously; the partial word is discarded with no `word_done`.
  - After release the block is in IDLE with `load_ready`=1.
- **Idle line:** `serial_out` is held 0 whenever `frame_en`=0.

## Test plan

- **Reset values:** assert `rst` for 3 cycles with `load_valid`=1 → `load_ready`=0, `frame_en`=0, `serial_out`=0, `word_done`=0; after release, `load_ready`=1.
- **Single word:** N=4, load 4'b1011 → `serial_out` = 1,0,1,1 over 4 cycles with `frame_en`=1; `word_done` pulses in cycle 4; looped-back SIPO reads 4'b1011 in that cycle; block returns to IDLE.
- **Back-to-back:** load 4'b1011 then 4'b0110 with `load_valid` held → 8 consecutive `frame_en` cycles, bits 1,0,1,1,0,1,1,0; `word_done` in cycles 4 and 8; SIPO reads 1011 then 0110.
- **Backpressure:** change `parallel_in` to 4'b1111 while `cnt`=1 with `load_valid`=1 → `load_ready`=0, transmitted word unaffected; 1111 is accepted only on the last bit cycle.
- **Reset mid-frame:** assert `rst` after bit 2 of 4'b1100 → outputs 0 immediately, no `word_done`; the next load of 4'b0101 transmits cleanly.
- **Width parameter:** N=8, load 8'hA5 → bits 1,0,1,0,0,1,0,1; `frame_en` high 8 cycles; `word_done` in cycle 8; SIPO reads 8'hA5.
